// File: rtl/gate_mon_pkg.sv
// Shared types and default sizing for the gate-cell output monitor and its helpers.
// Only types and constants live here; no logic.
package gate_mon_pkg;

    typedef enum logic {
        FALL = 1'b0,
        RISE = 1'b1
    } evt_dir_t;

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } filt_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_CYCLES = 3;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/bit_sync.sv
// Purpose: N-flop single-bit synchronizer for an asynchronous input.
// Latency: N clk edges from capture to q.
// Backpressure: none; free-running.
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/gate_out_monitor.sv
// Purpose: sync, optionally deglitch (GATE_OUT_MON_FILTER_EN), and report edges of the gate cell output.
// Latency: SYNC_STAGES+FILT_CYCLES edges with the filter, SYNC_STAGES+1 without.
// Backpressure: single-entry event register; an edge arriving while it is held and not taken is dropped and sets ovf.
module gate_out_monitor
    import gate_mon_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate_out,
    input  logic             clr,
    input  logic             evt_rdy,
    output logic             evt_vld,
    output logic             evt_rise,
    output logic             level,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_CYCLES < 1 || FILT_CYCLES > 15) begin : g_bad_param
        $error("gate_out_monitor: SYNC_STAGES or FILT_CYCLES out of range");
    end

    logic s;

    bit_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gate_out),
        .q     (s)
    );

    logic level_q, level_d;
    logic lvl_chg;

`ifdef GATE_OUT_MON_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

    filt_state_t state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Level only follows s after it has disagreed for FILT_CYCLES consecutive edges.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        level_d = level_q;
        lvl_chg = 1'b0;
        case (state_q)
            STABLE: begin
                fcnt_d = '0;
                if (s != level_q) begin
                    if (FILT_CYCLES == 1) begin
                        level_d = s;
                        lvl_chg = 1'b1;
                    end else begin
                        state_d = PEND;
                        fcnt_d  = 4'd1;
                    end
                end
            end
            PEND: begin
                if (s == level_q) begin
                    state_d = STABLE;
                    fcnt_d  = '0;
                end else if (fcnt_q == FILT_LAST) begin
                    state_d = STABLE;
                    fcnt_d  = '0;
                    level_d = s;
                    lvl_chg = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = STABLE;
                fcnt_d  = '0;
            end
        endcase
    end
`else
    always_comb begin
        level_d = s;
        lvl_chg = (s != level_q);
    end
`endif

    logic             vld_q, vld_d;
    evt_dir_t         rise_q, rise_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;

    assign xfer = vld_q && evt_rdy;

    // clr is applied last so it overrides a coincident count or drop.
    always_comb begin
        vld_d  = vld_q;
        rise_d = rise_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        if (xfer) begin
            vld_d = 1'b0;
        end
        if (lvl_chg) begin
            if (!vld_q || xfer) begin
                vld_d  = 1'b1;
                rise_d = evt_dir_t'(level_d);
            end else begin
                ovf_d = 1'b1;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            vld_q   <= 1'b0;
            rise_q  <= FALL;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            vld_q   <= vld_d;
            rise_q  <= rise_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level    = level_q;
    assign evt_vld  = vld_q;
    assign evt_rise = rise_q;
    assign ovf      = ovf_q;
    assign evt_cnt  = cnt_q;

endmodule

// File: tb/tb_gate_out_monitor.sv
// Bench for gate_out_monitor: default-width and 3-bit-counter instances share stimulus and are
// checked every cycle against a behavioural model, plus directed literal expectations.
module tb_gate_out_monitor;
    import gate_mon_pkg::*;

    localparam int SYNC = DEF_SYNC_STAGES;
    localparam int FILT = DEF_FILT_CYCLES;
`ifdef GATE_OUT_MON_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int LAT = FILT_ON ? SYNC + FILT : SYNC + 1;

    logic clk, rst_n, gate_out, clr, evt_rdy;
    logic a_vld, a_rise, a_level, a_ovf;
    logic [7:0] a_cnt;
    logic b_vld, b_rise, b_level, b_ovf;
    logic [2:0] b_cnt;

    gate_out_monitor #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .gate_out(gate_out), .clr(clr), .evt_rdy(evt_rdy),
        .evt_vld(a_vld), .evt_rise(a_rise), .level(a_level), .evt_cnt(a_cnt), .ovf(a_ovf));

    gate_out_monitor #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .gate_out(gate_out), .clr(clr), .evt_rdy(evt_rdy),
        .evt_vld(b_vld), .evt_rise(b_rise), .level(b_level), .evt_cnt(b_cnt), .ovf(b_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: s is gate_out as seen SYNC edges ago; level follows s after FILT consecutive
    // disagreeing edges (or immediately without the filter).
    bit hist [SYNC];
    bit m_lvl, m_vld, m_rise, m_ovf;
    int m_run, m_cnt_a, m_cnt_b;

    always @(posedge clk or negedge rst_n) begin
        bit s, chg;
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            m_lvl = 0; m_vld = 0; m_rise = 0; m_ovf = 0;
            m_run = 0; m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            s = hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gate_out;
            chg = 1'b0;
            if (s != m_lvl) begin
                m_run++;
                if (!FILT_ON || m_run >= FILT) begin
                    chg = 1'b1; m_lvl = s; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_vld && evt_rdy) m_vld = 1'b0;
            if (chg) begin
                if (m_vld) m_ovf = 1'b1;
                else begin m_vld = 1'b1; m_rise = m_lvl; end
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 7) m_cnt_b++;
            end
            if (clr) begin m_cnt_a = 0; m_cnt_b = 0; m_ovf = 1'b0; end
        end
    end

    always @(negedge clk) begin
        check("out_a", {20'b0, a_level, a_vld, a_rise, a_ovf, a_cnt},
                       {20'b0, m_lvl, m_vld, m_rise, m_ovf, 8'(m_cnt_a)});
        check("out_b", {25'b0, b_level, b_vld, b_rise, b_ovf, b_cnt},
                       {25'b0, m_lvl, m_vld, m_rise, m_ovf, 3'(m_cnt_b)});
    end

    int cyc = 0;
    int pul_cyc[$];
    bit pul_rise[$];

    task automatic poll(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cyc++;
            if (a_vld) begin
                pul_cyc.push_back(cyc);
                pul_rise.push_back(a_rise);
            end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1; poll(1); clr = 1'b0;
    endtask

    int tog_cyc[6];
    bit tog_dir[6];
    int e;
    int nv;

    initial begin
        rst_n = 1'b0; gate_out = 1'b1; clr = 1'b0; evt_rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_level", a_level, 0);
        check("rst_vld", a_vld, 0);
        check("rst_cnt", a_cnt, 0);

        // Release reset with gate_out already high: the event appears only after the full latency.
        @(negedge clk);
        rst_n = 1'b1;
        e = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (a_vld) begin e = i; break; end
        end
        check("rel_latency", e, LAT);
        check("rel_rise", a_rise, 1);
        check("rel_level", a_level, 1);
        check("rel_cnt", a_cnt, 1);
        evt_rdy = 1'b1;
        poll(2);
        check("rel_accepted", a_vld, 0);

`ifdef GATE_OUT_MON_FILTER_EN
        gate_out = 1'b0;
        poll(LAT + 3);
        pulse_clr();
        pul_cyc.delete(); pul_rise.delete();
        gate_out = 1'b1; poll(2);
        gate_out = 1'b0; poll(12);
        check("glitch_level", a_level, 0);
        check("glitch_cnt", a_cnt, 0);
        check("glitch_events", pul_cyc.size(), 0);
`endif

        // Toggle every 4 cycles with the consumer always ready.
        pulse_clr();
        poll(2);
        pul_cyc.delete(); pul_rise.delete();
        for (int k = 0; k < 6; k++) begin
            gate_out = ~gate_out;
            tog_cyc[k] = cyc;
            tog_dir[k] = gate_out;
            poll(4);
        end
        poll(LAT + 4);
        check("tog_pulses", pul_cyc.size(), 6);
        for (int k = 0; k < 6 && k < pul_cyc.size(); k++) begin
            check("tog_latency", pul_cyc[k] - tog_cyc[k], LAT);
            check("tog_dir", pul_rise[k], tog_dir[k]);
        end
        check("tog_cnt", a_cnt, 6);

        // Back-pressure: second edge dropped, first event held.
        pulse_clr();
        evt_rdy = 1'b0;
        gate_out = ~gate_out;
        tog_dir[0] = gate_out;
        poll(6);
        gate_out = ~gate_out;
        poll(LAT + 2);
        check("bp_vld", a_vld, 1);
        check("bp_rise", a_rise, tog_dir[0]);
        check("bp_ovf", a_ovf, 1);
        check("bp_cnt", a_cnt, 2);
        evt_rdy = 1'b1;
        poll(1);
        check("bp_after_xfer", a_vld, 0);

        // Saturation: 10 edges, the last two arriving with the consumer stalled.
        pulse_clr();
        for (int k = 0; k < 10; k++) begin
            if (k == 8) evt_rdy = 1'b0;
            gate_out = ~gate_out;
            poll(6);
        end
        check("sat_cnt_a", a_cnt, 10);
        check("sat_cnt_b", b_cnt, 7);
        check("sat_ovf", a_ovf, 1);
        gate_out = ~gate_out;
        poll(LAT - 1);
        clr = 1'b1;
        poll(1);
        clr = 1'b0;
        check("clr_edge_level", a_level, gate_out);
        check("clr_edge_cnt_a", a_cnt, 0);
        check("clr_edge_cnt_b", b_cnt, 0);
        check("clr_edge_ovf", a_ovf, 0);
        check("clr_edge_vld_held", a_vld, 1);

        // Reset while an event is held and a level change is in flight.
        gate_out = ~gate_out;
        poll(LAT - 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_a", {a_level, a_vld, a_rise, a_ovf, a_cnt}, 12'h000);
        check("midrst_b", {b_level, b_vld, b_rise, b_ovf, b_cnt}, 7'h00);
        gate_out = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_vld || b_vld) nv++;
        end
        check("midrst_no_evt", nv, 0);
        check("midrst_level", a_level, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
